// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, and a
// valid/ready output register carrying each word with parity and framing status.
module uart_rx #(
    parameter int    clk_rate = 50_000_000,
    parameter int    Baud     = 115200,
    parameter int    Word_len = 8,
    parameter string PARITY   = "even"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err
);

    localparam int Baud_div = clk_rate / Baud;
    localparam int Half_div = Baud_div / 2;
    localparam int CNT_W    = (Baud_div > 1) ? $clog2(Baud_div) : 1;
    localparam int BIT_W    = (Word_len > 1) ? $clog2(Word_len) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(Baud_div - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Half_div - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(Word_len - 1);
    localparam bit               PAR_EN    = (PARITY != "none");
    localparam bit               PAR_ODD   = (PARITY == "odd");

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic [CNT_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [Word_len-1:0] shift_reg;
    logic                par_bit;
    logic                par_mismatch;

    // Parity error for the word currently in the shift register; the odd case
    // simply inverts the expected bit, and no parity means never an error.
    assign par_mismatch = PAR_EN && (par_bit ^ (^shift_reg) ^ PAR_ODD);

    // Two-flop synchronizer; both stages reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM plus output register; the FSM never waits on the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_bit       <= 1'b0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[Word_len-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= PAR_EN ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PAR: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        par_bit  <= rx_s;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : BREAK;
                        if (!rx_data_valid || rx_data_ready) begin
                            rx_data       <= shift_reg;
                            parity_err    <= par_mismatch;
                            frame_err     <= ~rx_s;
                            rx_data_valid <= 1'b1;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, even parity, 8 data bits.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_line;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    int tests_run    = 0;
    int tests_failed = 0;

    int         word_cnt     = 0;
    int         valid_cycles = 0;
    int         ovr_cnt      = 0;
    logic [7:0] last_word    = '0;
    logic       last_pe      = 1'b0;
    logic       last_fe      = 1'b0;

    uart_rx #(
        .clk_rate(1_600_000),
        .Baud    (100_000),
        .Word_len(8),
        .PARITY  ("even")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Uart_rx      (uart_line),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Observe the handshake away from the rising edge and record accepted words
    always @(negedge clk) begin
        if (rx_data_valid) valid_cycles++;
        if (overrun_err) ovr_cnt++;
        if (rx_data_valid && rx_data_ready) begin
            word_cnt++;
            last_word = rx_data;
            last_pe   = parity_err;
            last_fe   = frame_err;
        end
    end

    task automatic clear_counts();
        word_cnt     = 0;
        valid_cycles = 0;
        ovr_cnt      = 0;
    endtask

    // Hold the line at one level for n clocks; returns 1 ns after a rising edge
    task automatic drive_bit(input logic b, input int n);
        uart_line = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full frame: start, 8 data bits LSB-first, parity bit, stop bit
    task automatic apply_stimulus(input logic [7:0] d, input logic p, input logic s);
        logic [7:0] v;
        v = d;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(v[i], 16);
        drive_bit(p, 16);
        drive_bit(s, 16);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        uart_line     = 1'b1;
        rx_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data got %h want 00", rx_data); end
        tests_run++;
        if (rx_data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", rx_data_valid); end
        tests_run++;
        if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_flags got %b want 000", {parity_err, frame_err, overrun_err});
        end
        rst = 1'b0;
        drive_bit(1'b1, 20);
        tests_run++;
        if (rx_data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_valid got %b want 0", rx_data_valid); end
    endtask

    task automatic test_basic();
        rx_data_ready = 1'b1;
        clear_counts();
        apply_stimulus(8'hA5, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (word_cnt !== 1) begin tests_failed++; $display("[TB] FAIL basic_count got %0d want 1", word_cnt); end
        tests_run++;
        if (last_word !== 8'hA5) begin tests_failed++; $display("[TB] FAIL basic_data got %h want a5", last_word); end
        tests_run++;
        if ({last_pe, last_fe} !== 2'b00) begin tests_failed++; $display("[TB] FAIL basic_flags got %b want 00", {last_pe, last_fe}); end
        tests_run++;
        if (valid_cycles !== 1) begin tests_failed++; $display("[TB] FAIL basic_valid_len got %0d want 1", valid_cycles); end
        tests_run++;
        if (rx_data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_valid_drop got %b want 0", rx_data_valid); end
    endtask

    task automatic test_parity();
        rx_data_ready = 1'b1;
        clear_counts();
        apply_stimulus(8'h01, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (last_word !== 8'h01) begin tests_failed++; $display("[TB] FAIL parity_data got %h want 01", last_word); end
        tests_run++;
        if (last_pe !== 1'b1) begin tests_failed++; $display("[TB] FAIL parity_err_set got %b want 1", last_pe); end
        apply_stimulus(8'h03, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (word_cnt !== 2) begin tests_failed++; $display("[TB] FAIL parity_count got %0d want 2", word_cnt); end
        tests_run++;
        if ({last_word, last_pe} !== {8'h03, 1'b0}) begin
            tests_failed++; $display("[TB] FAIL parity_err_clear got %h/%b want 03/0", last_word, last_pe);
        end
    endtask

    task automatic test_frame();
        rx_data_ready = 1'b1;
        clear_counts();
        apply_stimulus(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 40);
        tests_run++;
        if (word_cnt !== 1) begin tests_failed++; $display("[TB] FAIL frame_count got %0d want 1", word_cnt); end
        tests_run++;
        if ({last_word, last_pe, last_fe} !== {8'h3C, 1'b0, 1'b1}) begin
            tests_failed++; $display("[TB] FAIL frame_word got %h/%b/%b want 3c/0/1", last_word, last_pe, last_fe);
        end
        drive_bit(1'b1, 200);
        tests_run++;
        if (word_cnt !== 1) begin tests_failed++; $display("[TB] FAIL frame_no_retrigger got %0d want 1", word_cnt); end
    endtask

    task automatic test_back_to_back();
        rx_data_ready = 1'b0;
        clear_counts();
        apply_stimulus(8'h11, 1'b0, 1'b1);
        apply_stimulus(8'h22, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (rx_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL overrun_data got %h want 11", rx_data); end
        tests_run++;
        if (rx_data_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_valid got %b want 1", rx_data_valid); end
        tests_run++;
        if (ovr_cnt !== 1) begin tests_failed++; $display("[TB] FAIL overrun_pulse got %0d want 1", ovr_cnt); end
        rx_data_ready = 1'b1;
        drive_bit(1'b1, 3);
        tests_run++;
        if (word_cnt !== 1 || last_word !== 8'h11) begin
            tests_failed++; $display("[TB] FAIL overrun_accept got %0d/%h want 1/11", word_cnt, last_word);
        end
        tests_run++;
        if (rx_data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL overrun_valid_drop got %b want 0", rx_data_valid); end
    endtask

    task automatic test_glitch();
        rx_data_ready = 1'b1;
        clear_counts();
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 60);
        tests_run++;
        if (valid_cycles !== 0) begin tests_failed++; $display("[TB] FAIL glitch_valid got %0d want 0", valid_cycles); end
        apply_stimulus(8'h66, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (word_cnt !== 1 || last_word !== 8'h66) begin
            tests_failed++; $display("[TB] FAIL glitch_recover got %0d/%h want 1/66", word_cnt, last_word);
        end
    endtask

    task automatic test_reset_mid();
        rx_data_ready = 1'b0;
        apply_stimulus(8'h0F, 1'b0, 1'b0);
        drive_bit(1'b1, 20);
        tests_run++;
        if ({rx_data_valid, frame_err, rx_data} !== {1'b1, 1'b1, 8'h0F}) begin
            tests_failed++; $display("[TB] FAIL pre_reset_word got %b/%b/%h want 1/1/0f", rx_data_valid, frame_err, rx_data);
        end
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        rst = 1'b1;
        drive_bit(1'b1, 3);
        rst = 1'b0;
        tests_run++;
        if ({rx_data_valid, parity_err, frame_err, overrun_err, rx_data} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs got %b%b%b%b/%h want 0000/00",
                     rx_data_valid, parity_err, frame_err, overrun_err, rx_data);
        end
        drive_bit(1'b1, 200);
        rx_data_ready = 1'b1;
        clear_counts();
        apply_stimulus(8'h5A, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (word_cnt !== 1) begin tests_failed++; $display("[TB] FAIL midreset_count got %0d want 1", word_cnt); end
        tests_run++;
        if ({last_word, last_pe, last_fe} !== {8'h5A, 1'b0, 1'b0}) begin
            tests_failed++; $display("[TB] FAIL midreset_word got %h/%b/%b want 5a/0/0", last_word, last_pe, last_fe);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
